// File: rtl/execute_alu_operand_skid_pkg.sv
// Shared encodings and types for the ALU operand staging buffer.
// Holds the imm-mux select encodings, fixed datapath widths and the
// buffer occupancy state type.
package execute_alu_operand_skid_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned SEL_W  = 2;

  // Imm-mux select encodings
  localparam logic [SEL_W-1:0] ALU_IMPL_LUT6OPT_BYPASS   = 2'b00;
  localparam logic [SEL_W-1:0] ALU_IMPL_LUT6OPT_IMM_ZEXT = 2'b01;
  localparam logic [SEL_W-1:0] ALU_IMPL_LUT6OPT_IMM_SEXT = 2'b10;
  localparam logic [SEL_W-1:0] ALU_IMPL_LUT6OPT_IMM_LUI  = 2'b11;

  // Buffer occupancy: EMPTY (no head), HOLD (head only), FULL (head + skid)
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HOLD  = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

  // Only BYPASS consumes the source operand; other modes never wait on it
  function automatic logic sel_needs_src0(input logic [SEL_W-1:0] sel);
    return (sel == ALU_IMPL_LUT6OPT_BYPASS);
  endfunction

endpackage

// File: rtl/execute_alu_operand_entry.sv
// Single staging entry: holds one ALU op and snoops the writeback forward
// bus to capture a pending source operand.
// Ports:
//   clk, resetn       clock, async active-low reset
//   i_flush           drop the entry (data fields keep their values)
//   i_load            load a new op from the i_* fields
//   i_clear           release the entry (op popped / moved)
//   i_src0..i_dst     op fields to load; i_src0_rdy says i_src0 is valid
//   fwd_valid/tag/data writeback forward bus
//   o_vld..o_dst      stored entry contents
module execute_alu_operand_entry
  import execute_alu_operand_skid_pkg::*;
#(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned DST_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_src0,
  input  logic              i_src0_rdy,
  input  logic [TAG_W-1:0]  i_src0_tag,
  input  logic [IMM_W-1:0]  i_imm,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [DST_W-1:0]  i_dst,
  input  logic              fwd_valid,
  input  logic [TAG_W-1:0]  fwd_tag,
  input  logic [DATA_W-1:0] fwd_data,
  output logic              o_vld,
  output logic              o_rdy,
  output logic [DATA_W-1:0] o_src0,
  output logic [TAG_W-1:0]  o_tag,
  output logic [IMM_W-1:0]  o_imm,
  output logic [SEL_W-1:0]  o_sel,
  output logic [DST_W-1:0]  o_dst
);

  logic              r_vld;
  logic              r_rdy;
  logic [DATA_W-1:0] r_src0;
  logic [TAG_W-1:0]  r_tag;
  logic [IMM_W-1:0]  r_imm;
  logic [SEL_W-1:0]  r_sel;
  logic [DST_W-1:0]  r_dst;

  logic w_in_hit;
  logic w_own_hit;

  // Incoming op whose operand is being forwarded in the same cycle
  assign w_in_hit  = fwd_valid & ~i_src0_rdy & (fwd_tag == i_src0_tag);
  // Stored op still waiting for its operand
  assign w_own_hit = r_vld & ~r_rdy & fwd_valid & (fwd_tag == r_tag);

  // Entry state; flush beats load beats clear beats capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld  <= 1'b0;
      r_rdy  <= 1'b0;
      r_src0 <= '0;
      r_tag  <= '0;
      r_imm  <= '0;
      r_sel  <= '0;
      r_dst  <= '0;
    end else if (i_flush) begin
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_rdy  <= i_src0_rdy | w_in_hit;
      r_src0 <= w_in_hit ? fwd_data : i_src0;
      r_tag  <= i_src0_tag;
      r_imm  <= i_imm;
      r_sel  <= i_sel;
      r_dst  <= i_dst;
    end else if (i_clear) begin
      r_vld <= 1'b0;
    end else if (w_own_hit) begin
      r_src0 <= fwd_data;
      r_rdy  <= 1'b1;
    end
  end

  assign o_vld  = r_vld;
  assign o_rdy  = r_rdy;
  assign o_src0 = r_src0;
  assign o_tag  = r_tag;
  assign o_imm  = r_imm;
  assign o_sel  = r_sel;
  assign o_dst  = r_dst;

endmodule

// File: rtl/execute_alu_operand_skid.sv
// Two-entry operand staging buffer in front of the ALU imm/bypass mux.
// Accepts issued ops over valid/ready, holds them in head (M) and skid (S)
// entries, captures late operands from the writeback forward bus and drives
// d0/d1/sel straight from the head entry.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   i_flush                     synchronous pipeline flush
//   s_valid/s_ready             upstream handshake (s_ready flop-derived)
//   s_src0/_rdy/_tag, s_imm,
//   s_sel, s_dst                issued op fields
//   fwd_valid/fwd_tag/fwd_data  writeback forward bus
//   m_valid/m_ready             downstream handshake to the ALU
//   m_d0/m_d1/m_sel/m_dst       head op to imm mux
module execute_alu_operand_skid
  import execute_alu_operand_skid_pkg::*;
#(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned DST_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_src0,
  input  logic              s_src0_rdy,
  input  logic [TAG_W-1:0]  s_src0_tag,
  input  logic [IMM_W-1:0]  s_imm,
  input  logic [SEL_W-1:0]  s_sel,
  input  logic [DST_W-1:0]  s_dst,
  input  logic              fwd_valid,
  input  logic [TAG_W-1:0]  fwd_tag,
  input  logic [DATA_W-1:0] fwd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_d0,
  output logic [IMM_W-1:0]  m_d1,
  output logic [SEL_W-1:0]  m_sel,
  output logic [DST_W-1:0]  m_dst
);

  skid_state_e r_state;
  skid_state_e w_state_nxt;

  logic w_accept;
  logic w_pop;

  logic w_m_load;
  logic w_m_from_s;
  logic w_m_clear;
  logic w_s_load;
  logic w_s_clear;

  // Head entry contents
  logic              w_m_vld;
  logic              w_m_rdy;
  logic [DATA_W-1:0] w_m_src0;
  logic [TAG_W-1:0]  w_m_tag_unused;
  logic [IMM_W-1:0]  w_m_imm;
  logic [SEL_W-1:0]  w_m_sel;
  logic [DST_W-1:0]  w_m_dst;

  // Skid entry contents
  logic              w_s_vld;
  logic              w_s_rdy;
  logic [DATA_W-1:0] w_s_src0;
  logic [TAG_W-1:0]  w_s_tag;
  logic [IMM_W-1:0]  w_s_imm;
  logic [SEL_W-1:0]  w_s_sel;
  logic [DST_W-1:0]  w_s_dst;

  // Head load source: upstream op or the skid entry
  logic              w_m_in_rdy;
  logic [DATA_W-1:0] w_m_in_src0;
  logic [TAG_W-1:0]  w_m_in_tag;
  logic [IMM_W-1:0]  w_m_in_imm;
  logic [SEL_W-1:0]  w_m_in_sel;
  logic [DST_W-1:0]  w_m_in_dst;

  // Handshakes are functions of flops only; no m_ready -> s_ready path
  assign s_ready  = ~w_s_vld;
  assign m_valid  = w_m_vld & (w_m_rdy | ~sel_needs_src0(w_m_sel));
  assign w_accept = s_valid & s_ready;
  assign w_pop    = m_valid & m_ready;

  // Occupancy state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and entry load/clear control
  always_comb begin
    w_state_nxt = r_state;
    w_m_load    = 1'b0;
    w_m_from_s  = 1'b0;
    w_m_clear   = 1'b0;
    w_s_load    = 1'b0;
    w_s_clear   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_m_load    = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_pop && w_accept) begin
          w_m_load = 1'b1;
        end else if (w_pop) begin
          w_m_clear   = 1'b1;
          w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
          w_s_load    = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_pop) begin
          w_m_load    = 1'b1;
          w_m_from_s  = 1'b1;
          w_s_clear   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // Skid->head move carries the skid's capture status, so a forward
  // arriving on the move cycle is still picked up by the head entry
  assign w_m_in_rdy  = w_m_from_s ? w_s_rdy  : s_src0_rdy;
  assign w_m_in_src0 = w_m_from_s ? w_s_src0 : s_src0;
  assign w_m_in_tag  = w_m_from_s ? w_s_tag  : s_src0_tag;
  assign w_m_in_imm  = w_m_from_s ? w_s_imm  : s_imm;
  assign w_m_in_sel  = w_m_from_s ? w_s_sel  : s_sel;
  assign w_m_in_dst  = w_m_from_s ? w_s_dst  : s_dst;

  execute_alu_operand_entry #(
    .TAG_W (TAG_W),
    .DST_W (DST_W)
  ) u_entry_m (
    .clk        (clk),
    .resetn     (resetn),
    .i_flush    (i_flush),
    .i_load     (w_m_load),
    .i_clear    (w_m_clear),
    .i_src0     (w_m_in_src0),
    .i_src0_rdy (w_m_in_rdy),
    .i_src0_tag (w_m_in_tag),
    .i_imm      (w_m_in_imm),
    .i_sel      (w_m_in_sel),
    .i_dst      (w_m_in_dst),
    .fwd_valid  (fwd_valid),
    .fwd_tag    (fwd_tag),
    .fwd_data   (fwd_data),
    .o_vld      (w_m_vld),
    .o_rdy      (w_m_rdy),
    .o_src0     (w_m_src0),
    .o_tag      (w_m_tag_unused),
    .o_imm      (w_m_imm),
    .o_sel      (w_m_sel),
    .o_dst      (w_m_dst)
  );

  execute_alu_operand_entry #(
    .TAG_W (TAG_W),
    .DST_W (DST_W)
  ) u_entry_s (
    .clk        (clk),
    .resetn     (resetn),
    .i_flush    (i_flush),
    .i_load     (w_s_load),
    .i_clear    (w_s_clear),
    .i_src0     (s_src0),
    .i_src0_rdy (s_src0_rdy),
    .i_src0_tag (s_src0_tag),
    .i_imm      (s_imm),
    .i_sel      (s_sel),
    .i_dst      (s_dst),
    .fwd_valid  (fwd_valid),
    .fwd_tag    (fwd_tag),
    .fwd_data   (fwd_data),
    .o_vld      (w_s_vld),
    .o_rdy      (w_s_rdy),
    .o_src0     (w_s_src0),
    .o_tag      (w_s_tag),
    .o_imm      (w_s_imm),
    .o_sel      (w_s_sel),
    .o_dst      (w_s_dst)
  );

  assign m_d0  = w_m_src0;
  assign m_d1  = w_m_imm;
  assign m_sel = w_m_sel;
  assign m_dst = w_m_dst;

endmodule

// File: tb/tb_execute_alu_operand_skid.sv
// Directed self-checking bench for execute_alu_operand_skid.
module tb_execute_alu_operand_skid;

  localparam int unsigned TAG_W = 5;
  localparam int unsigned DST_W = 5;

  localparam logic [1:0] SEL_BYPASS = 2'b00;
  localparam logic [1:0] SEL_SEXT   = 2'b10;
  localparam logic [1:0] SEL_LUI    = 2'b11;

  logic             clk;
  logic             resetn;
  logic             i_flush;
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_src0;
  logic             s_src0_rdy;
  logic [TAG_W-1:0] s_src0_tag;
  logic [15:0]      s_imm;
  logic [1:0]       s_sel;
  logic [DST_W-1:0] s_dst;
  logic             fwd_valid;
  logic [TAG_W-1:0] fwd_tag;
  logic [31:0]      fwd_data;
  logic             m_valid;
  logic             m_ready;
  logic [31:0]      m_d0;
  logic [15:0]      m_d1;
  logic [1:0]       m_sel;
  logic [DST_W-1:0] m_dst;

  int n_assert;
  int n_fail;

  execute_alu_operand_skid #(
    .TAG_W (TAG_W),
    .DST_W (DST_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .i_flush    (i_flush),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_src0     (s_src0),
    .s_src0_rdy (s_src0_rdy),
    .s_src0_tag (s_src0_tag),
    .s_imm      (s_imm),
    .s_sel      (s_sel),
    .s_dst      (s_dst),
    .fwd_valid  (fwd_valid),
    .fwd_tag    (fwd_tag),
    .fwd_data   (fwd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_d0       (m_d0),
    .m_d1       (m_d1),
    .m_sel      (m_sel),
    .m_dst      (m_dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] src0, input logic rdy, input logic [TAG_W-1:0] tag,
                          input logic [15:0] imm, input logic [1:0] sel, input logic [DST_W-1:0] dst);
    s_valid    = 1'b1;
    s_src0     = src0;
    s_src0_rdy = rdy;
    s_src0_tag = tag;
    s_imm      = imm;
    s_sel      = sel;
    s_dst      = dst;
  endtask

  task automatic set_fwd(input logic v, input logic [TAG_W-1:0] tag, input logic [31:0] data);
    fwd_valid = v;
    fwd_tag   = tag;
    fwd_data  = data;
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    resetn     = 1'b1;
    i_flush    = 1'b0;
    s_valid    = 1'b0;
    s_src0     = '0;
    s_src0_rdy = 1'b0;
    s_src0_tag = '0;
    s_imm      = '0;
    s_sel      = '0;
    s_dst      = '0;
    m_ready    = 1'b0;
    set_fwd(1'b0, '0, '0);
    #1 resetn = 1'b0;
    #1;

    // Reset state
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_d0", m_d0, 32'd0);
    chk("rst_m_d1", 32'(m_d1), 32'd0);
    chk("rst_m_sel", 32'(m_sel), 32'd0);
    chk("rst_m_dst", 32'(m_dst), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("idle_m_valid", 32'(m_valid), 32'd0);
    chk("idle_s_ready", 32'(s_ready), 32'd1);

    // Streaming at full rate
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_op(32'h100 + 32'(i), 1'b1, '0, 16'h8001, SEL_SEXT, 5'd3);
      tick();
      chk("stream_m_valid", 32'(m_valid), 32'd1);
      chk("stream_m_d0", m_d0, 32'h100 + 32'(i));
      chk("stream_m_d1", 32'(m_d1), 32'h8001);
      chk("stream_m_sel", 32'(m_sel), 32'(SEL_SEXT));
      chk("stream_m_dst", 32'(m_dst), 32'd3);
      chk("stream_s_ready", 32'(s_ready), 32'd1);
    end
    s_valid = 1'b0;
    tick();
    chk("stream_drain", 32'(m_valid), 32'd0);

    // Backpressure: A,B fill the buffer, C waits upstream
    m_ready = 1'b0;
    drive_op(32'hAAAA_0001, 1'b1, '0, 16'h000A, SEL_BYPASS, 5'd1);
    tick();
    chk("bp_a_valid", 32'(m_valid), 32'd1);
    chk("bp_a_d0", m_d0, 32'hAAAA_0001);
    chk("bp_hold_ready", 32'(s_ready), 32'd1);
    drive_op(32'hBBBB_0002, 1'b1, '0, 16'h000B, SEL_BYPASS, 5'd2);
    tick();
    chk("bp_full_ready", 32'(s_ready), 32'd0);
    chk("bp_full_d0", m_d0, 32'hAAAA_0001);
    drive_op(32'hCCCC_0003, 1'b1, '0, 16'h000C, SEL_BYPASS, 5'd3);
    tick();
    chk("bp_c_blocked_ready", 32'(s_ready), 32'd0);
    chk("bp_c_blocked_d0", m_d0, 32'hAAAA_0001);
    m_ready = 1'b1;
    tick();
    chk("bp_b_valid", 32'(m_valid), 32'd1);
    chk("bp_b_d0", m_d0, 32'hBBBB_0002);
    chk("bp_b_dst", 32'(m_dst), 32'd2);
    chk("bp_b_s_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    chk("bp_c_d0", m_d0, 32'hCCCC_0003);
    chk("bp_c_dst", 32'(m_dst), 32'd3);
    tick();
    chk("bp_drain", 32'(m_valid), 32'd0);

    // Late operand via forward bus
    m_ready = 1'b1;
    drive_op(32'h5555_5555, 1'b0, 5'd7, 16'h0077, SEL_BYPASS, 5'd5);
    tick();
    s_valid = 1'b0;
    chk("fwd_wait1_valid", 32'(m_valid), 32'd0);
    chk("fwd_wait_d1", 32'(m_d1), 32'h0077);
    chk("fwd_wait_dst", 32'(m_dst), 32'd5);
    tick();
    chk("fwd_wait2_valid", 32'(m_valid), 32'd0);
    set_fwd(1'b1, 5'd6, 32'h1111_1111);
    tick();
    chk("fwd_wrongtag_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b0;
    set_fwd(1'b1, 5'd7, 32'hDEAD_BEEF);
    tick();
    chk("fwd_cap_valid", 32'(m_valid), 32'd1);
    chk("fwd_cap_d0", m_d0, 32'hDEAD_BEEF);
    set_fwd(1'b1, 5'd7, 32'h0);
    tick();
    chk("fwd_refwd_ignored_d0", m_d0, 32'hDEAD_BEEF);
    chk("fwd_refwd_valid", 32'(m_valid), 32'd1);
    set_fwd(1'b0, '0, '0);
    m_ready = 1'b1;
    tick();
    chk("fwd_drain", 32'(m_valid), 32'd0);

    // Same-cycle capture, then non-BYPASS op needing no operand
    m_ready = 1'b0;
    drive_op(32'h0, 1'b0, 5'd4, 16'h0044, SEL_BYPASS, 5'd6);
    set_fwd(1'b1, 5'd4, 32'h0000_1234);
    tick();
    set_fwd(1'b0, '0, '0);
    chk("same_cyc_valid", 32'(m_valid), 32'd1);
    chk("same_cyc_d0", m_d0, 32'h0000_1234);
    drive_op(32'h0, 1'b0, 5'd9, 16'hABCD, SEL_LUI, 5'd7);
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("lui_valid", 32'(m_valid), 32'd1);
    chk("lui_sel", 32'(m_sel), 32'(SEL_LUI));
    chk("lui_d1", 32'(m_d1), 32'hABCD);
    chk("lui_dst", 32'(m_dst), 32'd7);
    tick();
    chk("lui_held_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    tick();
    chk("lui_drain", 32'(m_valid), 32'd0);

    // Forward landing on the skid->head move cycle
    m_ready = 1'b0;
    drive_op(32'h0000_0001, 1'b1, '0, 16'h0001, SEL_BYPASS, 5'd1);
    tick();
    drive_op(32'h0, 1'b0, 5'd2, 16'h0002, SEL_BYPASS, 5'd2);
    tick();
    s_valid = 1'b0;
    chk("mv_full_ready", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    set_fwd(1'b1, 5'd2, 32'hCAFE_F00D);
    tick();
    set_fwd(1'b0, '0, '0);
    chk("mv_cap_valid", 32'(m_valid), 32'd1);
    chk("mv_cap_d0", m_d0, 32'hCAFE_F00D);
    chk("mv_cap_dst", 32'(m_dst), 32'd2);
    tick();
    chk("mv_drain", 32'(m_valid), 32'd0);

    // Flush while FULL with accept, pop and forward all requested
    m_ready = 1'b0;
    drive_op(32'h0000_0011, 1'b1, '0, 16'h1111, SEL_BYPASS, 5'd1);
    tick();
    drive_op(32'h0, 1'b0, 5'd3, 16'h2222, SEL_BYPASS, 5'd2);
    tick();
    chk("fl_full_ready", 32'(s_ready), 32'd0);
    drive_op(32'h0000_0033, 1'b0, 5'd3, 16'h3333, SEL_BYPASS, 5'd3);
    set_fwd(1'b1, 5'd3, 32'h0BAD_0BAD);
    m_ready = 1'b1;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    s_valid = 1'b0;
    set_fwd(1'b0, '0, '0);
    chk("fl_m_valid", 32'(m_valid), 32'd0);
    chk("fl_s_ready", 32'(s_ready), 32'd1);
    chk("fl_data_held_d1", 32'(m_d1), 32'h1111);
    tick();
    chk("fl_no_emit_valid", 32'(m_valid), 32'd0);
    chk("fl_no_emit_ready", 32'(s_ready), 32'd1);

    // Asynchronous reset while FULL
    m_ready = 1'b0;
    drive_op(32'h0000_0077, 1'b1, '0, 16'h0707, SEL_BYPASS, 5'd4);
    tick();
    drive_op(32'h0000_0088, 1'b1, '0, 16'h0808, SEL_BYPASS, 5'd5);
    tick();
    s_valid = 1'b0;
    chk("ar_full_ready", 32'(s_ready), 32'd0);
    chk("ar_full_valid", 32'(m_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_m_valid", 32'(m_valid), 32'd0);
    chk("ar_s_ready", 32'(s_ready), 32'd1);
    chk("ar_m_d0", m_d0, 32'd0);
    chk("ar_m_d1", 32'(m_d1), 32'd0);
    resetn = 1'b1;
    tick();
    chk("ar_idle_valid", 32'(m_valid), 32'd0);
    chk("ar_idle_ready", 32'(s_ready), 32'd1);
    chk("ar_idle_d0", m_d0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
